// File: rtl/double_to_sig16b.sv
// Iterative binary64 -> 16-bit sign-magnitude sample converter.
// Shifts out one magnitude bit per cycle, rounds half-up, saturates at 0x7FFF.
module double_to_sig16b (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] double,
   output logic        busy,
   output logic        done,
   output logic [15:0] sig16b,
   output logic        ovf
);

   localparam int unsigned EXP_W = 11;
   localparam int unsigned SH_W  = 54;
   localparam int unsigned ACC_W = 16;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, ROUND} state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [SH_W-1:0]    sh_q, sh_d;
   logic [ACC_W-1:0]   a_q, a_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               force_q, force_d;
   logic [14:0]        fmag_q, fmag_d;
   logic               fovf_q, fovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [15:0]        sig16b_q, sig16b_d;
   logic               ovf_q, ovf_d;

   logic               exp_zero, exp_max, man_nz, too_big, too_small, special;
   logic [CNT_W-1:0]   cnt_load;
   logic [16:0]        mag17;
   logic [14:0]        fin_mag;
   logic               fin_ovf;

   // Operand classification on the captured exponent (e = E - 1023)
   always_comb begin
      exp_zero  = (exp_q == '0);
      exp_max   = (exp_q == 11'h7FF);
      man_nz    = |sh_q[52:1];
      too_big   = (exp_q >= 11'd1038);
      too_small = (exp_q <= 11'd1021);
      special   = exp_zero | exp_max | too_big | too_small;
      cnt_load  = CNT_W'(exp_q - 11'd1022);
   end

   always_comb begin
      mag17 = 17'(a_q) + 17'(sh_q[SH_W-1]);
      if (force_q) begin
         fin_mag = fmag_q;
         fin_ovf = fovf_q;
      end else if (mag17 > 17'd32767) begin
         fin_mag = 15'h7FFF;
         fin_ovf = 1'b1;
      end else begin
         fin_mag = mag17[14:0];
         fin_ovf = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = CLASSIFY;
         CLASSIFY: if (special || cnt_load == '0) state_d = ROUND;
                   else                           state_d = SHIFT;
         SHIFT:    if (count_q == CNT_W'(1)) state_d = ROUND;
         ROUND:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      sign_d   = sign_q;
      exp_d    = exp_q;
      sh_d     = sh_q;
      a_d      = a_q;
      count_d  = count_q;
      force_d  = force_q;
      fmag_d   = fmag_q;
      fovf_d   = fovf_q;
      sig16b_d = sig16b_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      busy_d   = (state_d != IDLE);
      case (state_q)
         IDLE: if (start) begin
            sign_d  = double[63];
            exp_d   = double[62:52];
            sh_d    = {1'b1, double[51:0], 1'b0};
            a_d     = '0;
            force_d = 1'b0;
         end
         CLASSIFY: begin
            if (special) begin
               force_d = 1'b1;
               if (exp_max) begin
                  fmag_d = man_nz ? 15'h0000 : 15'h7FFF;
                  fovf_d = 1'b1;
               end else if (too_big) begin
                  fmag_d = 15'h7FFF;
                  fovf_d = 1'b1;
               end else begin
                  fmag_d = 15'h0000;
                  fovf_d = 1'b0;
               end
            end else begin
               count_d = cnt_load;
            end
         end
         SHIFT: begin
            a_d     = {a_q[ACC_W-2:0], sh_q[SH_W-1]};
            sh_d    = sh_q << 1;
            count_d = count_q - CNT_W'(1);
         end
         ROUND: begin
            // Sign suppressed on zero magnitude so -0 never leaves the block
            sig16b_d = {sign_q & (|fin_mag), fin_mag};
            ovf_d    = fin_ovf;
            done_d   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         sh_q     <= '0;
         a_q      <= '0;
         count_q  <= '0;
         force_q  <= 1'b0;
         fmag_q   <= '0;
         fovf_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sig16b_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         sh_q     <= sh_d;
         a_q      <= a_d;
         count_q  <= count_d;
         force_q  <= force_d;
         fmag_q   <= fmag_d;
         fovf_q   <= fovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sig16b_q <= sig16b_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign sig16b = sig16b_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_double_to_sig16b.sv
// Directed checks of double_to_sig16b: values, latency, handshake and reset abort.
module tb_double_to_sig16b;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] dbl;
   logic        busy, done, ovf;
   logic [15:0] sig16b;

   int vectors = 0;
   int fails   = 0;

   double_to_sig16b dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .double (dbl),
      .busy   (busy),
      .done   (done),
      .sig16b (sig16b),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One conversion; b2b keeps start in the current (done) cycle, poke re-pulses start while busy
   task automatic run(input string tag, input logic [63:0] d, input logic [15:0] es,
                      input logic eo, input int el, input bit b2b, input int poke);
      int cyc;
      bit busy_ok;
      if (!b2b) @(negedge clk);
      start = 1'b1;
      dbl   = d;
      @(posedge clk); #1;
      start = 1'b0;
      dbl   = 64'h3FF0_0000_0000_0000;
      cyc     = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (cyc == poke) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      chk({tag, "_lat"},    32'(cyc),    32'(el));
      chk({tag, "_sig"},    32'(sig16b), 32'(es));
      chk({tag, "_ovf"},    32'(ovf),    32'(eo));
      chk({tag, "_busy"},   32'(busy_ok), 32'd1);
      chk({tag, "_busy_lo"}, 32'(busy),  32'd0);
   endtask

   initial begin
      int extra;
      rst   = 1'b1;
      start = 1'b0;
      dbl   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sig",  32'(sig16b), 32'h0);
      chk("rst_ovf",  32'(ovf),    32'h0);
      chk("rst_busy", 32'(busy),   32'h0);
      chk("rst_done", 32'(done),   32'h0);
      @(negedge clk) rst = 1'b0;

      run("one", 64'h3FF0_0000_0000_0000, 16'h0001, 1'b0, 3, 1'b0, -1);
      @(posedge clk); #1;
      chk("one_pulse", 32'(done),   32'h0);
      chk("one_hold",  32'(sig16b), 32'h0001);

      run("m1234",  64'hC093_4800_0000_0000, 16'h84D2, 1'b0, 13, 1'b0, -1);
      run("p2_5",   64'h4004_0000_0000_0000, 16'h0003, 1'b0, 4,  1'b0, -1);
      run("p0_5",   64'h3FE0_0000_0000_0000, 16'h0001, 1'b0, 2,  1'b0, -1);
      run("p0_4",   64'h3FD9_9999_9999_999A, 16'h0000, 1'b0, 2,  1'b0, -1);
      run("mzero",  64'h8000_0000_0000_0000, 16'h0000, 1'b0, 2,  1'b0, -1);
      run("sat_rc", 64'h40DF_FFE0_0000_0000, 16'h7FFF, 1'b1, 17, 1'b0, -1);
      run("m40000", 64'hC0E3_8800_0000_0000, 16'hFFFF, 1'b1, 2,  1'b0, -1);
      run("pinf",   64'h7FF0_0000_0000_0000, 16'h7FFF, 1'b1, 2,  1'b0, -1);
      run("nan",    64'h7FF8_0000_0000_0000, 16'h0000, 1'b1, 2,  1'b0, -1);

      run("ignore", 64'h4093_4800_0000_0000, 16'h04D2, 1'b0, 13, 1'b0, 4);
      extra = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      chk("ignore_extra", 32'(extra),  32'd0);
      chk("ignore_hold",  32'(sig16b), 32'h04D2);

      run("b2b_a", 64'h4004_0000_0000_0000, 16'h0003, 1'b0, 4, 1'b0, -1);
      run("b2b_b", 64'h3FF0_0000_0000_0000, 16'h0001, 1'b0, 3, 1'b1, -1);

      // Abort -1234.0 mid-shift with an asynchronous reset
      @(negedge clk);
      start = 1'b1;
      dbl   = 64'hC093_4800_0000_0000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_sig",  32'(sig16b), 32'h0);
      chk("abort_ovf",  32'(ovf),    32'h0);
      chk("abort_busy", 32'(busy),   32'h0);
      chk("abort_done", 32'(done),   32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      extra = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      chk("abort_nodone", 32'(extra), 32'd0);
      run("after_rst", 64'h4004_0000_0000_0000, 16'h0003, 1'b0, 4, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
